// File: rtl/decode_stage.sv
// decode_stage: pipelined RV32I decoder between fetch and execute.
//   A BUF_DEPTH-entry FIFO absorbs fetch bursts. The FIFO head is decoded
//   combinationally and captured in a registered output stage that uses a
//   valid/ready handshake. Flush discards everything buffered or registered.
//   Optional macro M_EXT_EN adds RV32M decode (out_signal grows to 45 bits).
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   in_valid/in_ready/in_instr/in_pc fetch side (push when valid && ready)
//   flush                            drop all in-flight instructions
//   out_valid/out_ready              execute side handshake
//   out_pc, out_opcode               PC and opcode of the decoded instruction
//   out_rs1/out_rs2/out_rd           register indices, 0 when unused
//   out_rs1_valid/out_rs2_valid      register reads required
//   out_imm                          sign-extended immediate
//   out_signal                       one-hot instruction vector
//   out_illegal                      no out_signal bit set
module decode_stage #(
  parameter int BUF_DEPTH = 2,
  parameter int PC_WIDTH  = 32,
`ifdef M_EXT_EN
  localparam int SIG_W    = 45
`else
  localparam int SIG_W    = 37
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [PC_WIDTH-1:0] in_pc,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [6:0]          out_opcode,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [4:0]          out_rd,
  output logic                out_rs1_valid,
  output logic                out_rs2_valid,
  output logic [31:0]         out_imm,
  output logic [SIG_W-1:0]    out_signal,
  output logic                out_illegal
);

  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  logic [31:0]         instr_mem [BUF_DEPTH];
  logic [PC_WIDTH-1:0] pc_mem    [BUF_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [CW-1:0]       count;
  logic                nonempty;
  logic                load;
  logic                push;
  logic                pop;

  assign in_ready = (count != DEPTH_C);
  assign nonempty = (count != '0);
  assign load     = nonempty && (!out_valid || out_ready);
  assign push     = in_valid && in_ready && !flush;
  assign pop      = load && !flush;

  // ---- stage p0: FIFO write / pointer bookkeeping ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= in_instr;
      pc_mem[wr_ptr]    <= in_pc;
    end
  end

  // ---- stage p0: combinational decode of the FIFO head ----
  logic [31:0]         instr_p0;
  logic [PC_WIDTH-1:0] pc_p0;
  logic [6:0]          opc_p0;
  logic [2:0]          f3_p0;
  logic [6:0]          f7_p0;
  logic [SIG_W-1:0]    sig_p0;
  logic                illegal_p0;
  logic                is_r, is_i, is_s, is_b, is_u, is_j;
  logic                rs1_vld_p0, rs2_vld_p0, rd_used_p0;
  logic signed [31:0]  imm_p0;

  assign instr_p0 = instr_mem[rd_ptr];
  assign pc_p0    = pc_mem[rd_ptr];
  assign opc_p0   = instr_p0[6:0];
  assign f3_p0    = instr_p0[14:12];
  assign f7_p0    = instr_p0[31:25];

  always_comb begin
    sig_p0 = '0;
    case (opc_p0)
      7'b0110011: begin
        if (f7_p0 == 7'b0000000) begin
          case (f3_p0)
            3'd0: sig_p0[0] = 1'b1;
            3'd1: sig_p0[5] = 1'b1;
            3'd2: sig_p0[8] = 1'b1;
            3'd3: sig_p0[9] = 1'b1;
            3'd4: sig_p0[2] = 1'b1;
            3'd5: sig_p0[6] = 1'b1;
            3'd6: sig_p0[3] = 1'b1;
            default: sig_p0[4] = 1'b1;
          endcase
        end else if (f7_p0 == 7'b0100000) begin
          if (f3_p0 == 3'd0) sig_p0[1] = 1'b1;
          if (f3_p0 == 3'd5) sig_p0[7] = 1'b1;
`ifdef M_EXT_EN
        end else if (f7_p0 == 7'b0000001) begin
          // mul..remu occupy bits 37..44 in funct3 order
          sig_p0[44:37] = 8'b1 << f3_p0;
`endif
        end
      end
      7'b0010011: begin
        case (f3_p0)
          3'd0: sig_p0[10] = 1'b1;
          3'd1: sig_p0[14] = (f7_p0 == 7'b0000000);
          3'd2: sig_p0[17] = 1'b1;
          3'd3: sig_p0[18] = 1'b1;
          3'd4: sig_p0[11] = 1'b1;
          3'd5: begin
            sig_p0[15] = (f7_p0 == 7'b0000000);
            sig_p0[16] = (f7_p0 == 7'b0100000);
          end
          3'd6: sig_p0[12] = 1'b1;
          default: sig_p0[13] = 1'b1;
        endcase
      end
      7'b0000011: begin
        case (f3_p0)
          3'd0: sig_p0[19] = 1'b1;
          3'd1: sig_p0[20] = 1'b1;
          3'd2: sig_p0[21] = 1'b1;
          3'd4: sig_p0[22] = 1'b1;
          3'd5: sig_p0[23] = 1'b1;
          default: ;
        endcase
      end
      7'b0100011: begin
        case (f3_p0)
          3'd0: sig_p0[24] = 1'b1;
          3'd1: sig_p0[25] = 1'b1;
          3'd2: sig_p0[26] = 1'b1;
          default: ;
        endcase
      end
      7'b1100011: begin
        case (f3_p0)
          3'd0: sig_p0[27] = 1'b1;
          3'd1: sig_p0[28] = 1'b1;
          3'd4: sig_p0[29] = 1'b1;
          3'd5: sig_p0[30] = 1'b1;
          3'd6: sig_p0[31] = 1'b1;
          3'd7: sig_p0[32] = 1'b1;
          default: ;
        endcase
      end
      7'b1101111: sig_p0[33] = 1'b1;
      7'b1100111: sig_p0[34] = (f3_p0 == 3'd0);
      7'b0110111: sig_p0[35] = 1'b1;
      7'b0010111: sig_p0[36] = 1'b1;
      default: ;
    endcase
  end

  assign illegal_p0 = ~|sig_p0;
  assign is_r = (opc_p0 == 7'b0110011);
  assign is_i = (opc_p0 == 7'b0000011) || (opc_p0 == 7'b0010011) || (opc_p0 == 7'b1100111);
  assign is_s = (opc_p0 == 7'b0100011);
  assign is_b = (opc_p0 == 7'b1100011);
  assign is_u = (opc_p0 == 7'b0110111) || (opc_p0 == 7'b0010111);
  assign is_j = (opc_p0 == 7'b1101111);

  // Illegal encodings carry no operand or immediate information downstream.
  assign rd_used_p0 = !illegal_p0 && (is_r || is_i || is_u || is_j);
  assign rs1_vld_p0 = !illegal_p0 && (is_r || is_i || is_s || is_b);
  assign rs2_vld_p0 = !illegal_p0 && (is_r || is_s || is_b);

  always_comb begin
    imm_p0 = '0;
    if (!illegal_p0) begin
      if (is_i)      imm_p0 = $signed({{20{instr_p0[31]}}, instr_p0[31:20]});
      else if (is_s) imm_p0 = $signed({{20{instr_p0[31]}}, instr_p0[31:25], instr_p0[11:7]});
      else if (is_b) imm_p0 = $signed({{19{instr_p0[31]}}, instr_p0[31], instr_p0[7],
                                       instr_p0[30:25], instr_p0[11:8], 1'b0});
      else if (is_j) imm_p0 = $signed({{11{instr_p0[31]}}, instr_p0[31], instr_p0[19:12],
                                       instr_p0[20], instr_p0[30:21], 1'b0});
      else if (is_u) imm_p0 = $signed({instr_p0[31:12], 12'h000});
    end
  end

  // ---- stage p1: registered output with handshake ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_opcode    <= '0;
      out_rs1       <= '0;
      out_rs2       <= '0;
      out_rd        <= '0;
      out_rs1_valid <= 1'b0;
      out_rs2_valid <= 1'b0;
      out_imm       <= '0;
      out_signal    <= '0;
      out_illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid     <= 1'b1;
      out_pc        <= pc_p0;
      out_opcode    <= opc_p0;
      out_rs1       <= rs1_vld_p0 ? instr_p0[19:15] : 5'd0;
      out_rs2       <= rs2_vld_p0 ? instr_p0[24:20] : 5'd0;
      out_rd        <= rd_used_p0 ? instr_p0[11:7] : 5'd0;
      out_rs1_valid <= rs1_vld_p0;
      out_rs2_valid <= rs2_vld_p0;
      out_imm       <= imm_p0;
      out_signal    <= sig_p0;
      out_illegal   <= illegal_p0;
    end else if (out_ready) begin
      // accepted with nothing buffered behind it
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
`timescale 1ns/1ps
module tb_decode_stage;
`ifdef M_EXT_EN
  localparam int SIG_W = 45;
`else
  localparam int SIG_W = 37;
`endif
  localparam int BUF_DEPTH = 2;
  localparam int PC_WIDTH  = 32;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_instr;
  logic [PC_WIDTH-1:0] in_pc;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [PC_WIDTH-1:0] out_pc;
  logic [6:0]          out_opcode;
  logic [4:0]          out_rs1;
  logic [4:0]          out_rs2;
  logic [4:0]          out_rd;
  logic                out_rs1_valid;
  logic                out_rs2_valid;
  logic [31:0]         out_imm;
  logic [SIG_W-1:0]    out_signal;
  logic                out_illegal;

  decode_stage #(.BUF_DEPTH(BUF_DEPTH), .PC_WIDTH(PC_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_rs1_valid(out_rs1_valid), .out_rs2_valid(out_rs2_valid),
    .out_imm(out_imm), .out_signal(out_signal), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        v1;
    logic        v2;
    logic [31:0] imm;
    logic [44:0] sig;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    int          bitn;
    int          rd, rs1, rs2, v1, v2;
    logic [31:0] imm;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] pat_mask  [45];
  logic [31:0] pat_match [45];

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_pat(input int k, input logic [31:0] m, input logic [31:0] v);
    pat_mask[k]  = m;
    pat_match[k] = v;
  endtask

  task automatic fill_patterns();
    set_pat(0, 32'hFE00707F, 32'h00000033);  set_pat(1, 32'hFE00707F, 32'h40000033);
    set_pat(2, 32'hFE00707F, 32'h00004033);  set_pat(3, 32'hFE00707F, 32'h00006033);
    set_pat(4, 32'hFE00707F, 32'h00007033);  set_pat(5, 32'hFE00707F, 32'h00001033);
    set_pat(6, 32'hFE00707F, 32'h00005033);  set_pat(7, 32'hFE00707F, 32'h40005033);
    set_pat(8, 32'hFE00707F, 32'h00002033);  set_pat(9, 32'hFE00707F, 32'h00003033);
    set_pat(10, 32'h0000707F, 32'h00000013); set_pat(11, 32'h0000707F, 32'h00004013);
    set_pat(12, 32'h0000707F, 32'h00006013); set_pat(13, 32'h0000707F, 32'h00007013);
    set_pat(14, 32'hFE00707F, 32'h00001013); set_pat(15, 32'hFE00707F, 32'h00005013);
    set_pat(16, 32'hFE00707F, 32'h40005013); set_pat(17, 32'h0000707F, 32'h00002013);
    set_pat(18, 32'h0000707F, 32'h00003013); set_pat(19, 32'h0000707F, 32'h00000003);
    set_pat(20, 32'h0000707F, 32'h00001003); set_pat(21, 32'h0000707F, 32'h00002003);
    set_pat(22, 32'h0000707F, 32'h00004003); set_pat(23, 32'h0000707F, 32'h00005003);
    set_pat(24, 32'h0000707F, 32'h00000023); set_pat(25, 32'h0000707F, 32'h00001023);
    set_pat(26, 32'h0000707F, 32'h00002023); set_pat(27, 32'h0000707F, 32'h00000063);
    set_pat(28, 32'h0000707F, 32'h00001063); set_pat(29, 32'h0000707F, 32'h00004063);
    set_pat(30, 32'h0000707F, 32'h00005063); set_pat(31, 32'h0000707F, 32'h00006063);
    set_pat(32, 32'h0000707F, 32'h00007063); set_pat(33, 32'h0000007F, 32'h0000006F);
    set_pat(34, 32'h0000707F, 32'h00000067); set_pat(35, 32'h0000007F, 32'h00000037);
    set_pat(36, 32'h0000007F, 32'h00000017);
    for (int f = 0; f < 8; f++) set_pat(37 + f, 32'hFE00707F, 32'h02000033 | (f << 12));
  endtask

  // Reference decode: mnemonic pattern match plus format-level field rules.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    int   v;
    logic r, i, s, b, u, j;
    e = '0;
    e.pc  = pc;
    e.opc = ins[6:0];
    for (int k = 0; k < SIG_W; k++)
      if ((ins & pat_mask[k]) == pat_match[k]) e.sig[k] = 1'b1;
    e.ill = (e.sig == '0);
    if (e.ill) return e;
    r = (ins[6:0] == 7'h33);
    i = (ins[6:0] == 7'h03) || (ins[6:0] == 7'h13) || (ins[6:0] == 7'h67);
    s = (ins[6:0] == 7'h23);
    b = (ins[6:0] == 7'h63);
    u = (ins[6:0] == 7'h37) || (ins[6:0] == 7'h17);
    j = (ins[6:0] == 7'h6F);
    if (r || i || u || j) e.rd  = ins[11:7];
    if (r || i || s || b) begin e.rs1 = ins[19:15]; e.v1 = 1'b1; end
    if (r || s || b)      begin e.rs2 = ins[24:20]; e.v2 = 1'b1; end
    v = 0;
    if (i) begin
      v = int'(ins[31:20]);
      if (ins[31]) v -= 4096;
    end else if (s) begin
      v = int'(ins[31:25]) * 32 + int'(ins[11:7]);
      if (ins[31]) v -= 4096;
    end else if (b) begin
      v = int'(ins[31]) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
      if (ins[31]) v -= 8192;
    end else if (j) begin
      v = int'(ins[31]) * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
      if (ins[31]) v -= 2097152;
    end
    e.imm = u ? {ins[31:12], 12'h000} : 32'(v);
    return e;
  endfunction

  function automatic exp_t pack_out();
    exp_t a;
    a = '0;
    a.pc = out_pc; a.opc = out_opcode; a.rs1 = out_rs1; a.rs2 = out_rs2; a.rd = out_rd;
    a.v1 = out_rs1_valid; a.v2 = out_rs2_valid; a.imm = out_imm; a.ill = out_illegal;
    a.sig[SIG_W-1:0] = out_signal;
    return a;
  endfunction

  function automatic vec_t mkvec(input logic [31:0] ins, input int bitn, input int rd, input int rs1,
                                 input int rs2, input int v1, input int v2, input logic [31:0] imm);
    vec_t t;
    t.instr = ins; t.bitn = bitn; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2;
    t.v1 = v1; t.v2 = v2; t.imm = imm;
    return t;
  endfunction

  function automatic logic [31:0] gen_instr();
    int k;
    if ($urandom_range(0, 7) == 0) return $urandom;
    k = $urandom_range(0, 44);
    return pat_match[k] | ($urandom & ~pat_mask[k]);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic apply_vec(input vec_t t, input logic [31:0] pc);
    exp_t e;
    in_valid = 1'b1; in_instr = t.instr; in_pc = pc; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("vec_latency_valid_low", out_valid, 1'b0);
    @(posedge clk); #1;
    check("vec_valid", out_valid, 1'b1);
    e = '0;
    e.pc = pc; e.opc = t.instr[6:0];
    e.rd = 5'(t.rd); e.rs1 = 5'(t.rs1); e.rs2 = 5'(t.rs2);
    e.v1 = (t.v1 != 0); e.v2 = (t.v2 != 0); e.imm = t.imm;
    e.ill = (t.bitn < 0);
    if (t.bitn >= 0) e.sig = 45'(1) << t.bitn;
    check($sformatf("vec_%08h", t.instr), pack_out(), e);
  endtask

  vec_t vt[12];
  exp_t q[$];
  exp_t e;
  int   accepts, seen, nvalid, first, last, order_bad, rdy_drop;
  logic [31:0] bp_instr [8];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
    fill_patterns();

    // Reset state
    do_reset();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_fields", pack_out(), exp_t'('0));

    // Directed vectors
    vt[0]  = mkvec(32'h00500093, 10, 1, 0, 0, 1, 0, 32'h00000005);
    vt[1]  = mkvec(32'hFE208EE3, 27, 0, 1, 2, 1, 1, 32'hFFFFFFFC);
    vt[2]  = mkvec(32'h402081B3,  1, 3, 1, 2, 1, 1, 32'h00000000);
    vt[3]  = mkvec(32'hFFFFFFFF, -1, 0, 0, 0, 0, 0, 32'h00000000);
`ifdef M_EXT_EN
    vt[4]  = mkvec(32'h027302B3, 37, 5, 6, 7, 1, 1, 32'h00000000);
`else
    vt[4]  = mkvec(32'h027302B3, -1, 0, 0, 0, 0, 0, 32'h00000000);
`endif
    vt[5]  = mkvec(32'h123452B7, 35, 5, 0, 0, 0, 0, 32'h12345000);
    vt[6]  = mkvec(32'hFE20AC23, 26, 0, 1, 2, 1, 1, 32'hFFFFFFF8);
    vt[7]  = mkvec(32'h001000EF, 33, 1, 0, 0, 0, 0, 32'h00000800);
    vt[8]  = mkvec(32'h4030D093, 16, 1, 1, 0, 1, 0, 32'h00000403);
    vt[9]  = mkvec(32'h40309093, -1, 0, 0, 0, 0, 0, 32'h00000000);
    vt[10] = mkvec(32'hFFF1C203, 22, 4, 3, 0, 1, 0, 32'hFFFFFFFF);
    vt[11] = mkvec(32'h00001517, 36, 10, 0, 0, 0, 0, 32'h00001000);
    for (int v = 0; v < 12; v++) apply_vec(vt[v], 32'h100 + 32'(v) * 4);
    @(posedge clk); #1;

    // Backpressure until full, then in-order drain
    do_reset();
    out_ready = 1'b0; accepts = 0;
    bp_instr[0] = 32'h402081B3; bp_instr[1] = 32'h00500093; bp_instr[2] = 32'h0020C233;
    for (int k = 3; k < 8; k++) bp_instr[k] = 32'h00000013;
    for (int k = 0; k < 8; k++) begin
      if (!in_ready) break;
      in_valid = 1'b1; in_instr = bp_instr[accepts]; in_pc = 32'h200 + 32'(accepts) * 4;
      @(posedge clk); #1;
      accepts++;
    end
    in_valid = 1'b0;
    check("bp_accepts", accepts, BUF_DEPTH + 1);
    check("bp_in_ready_low", in_ready, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("bp_hold_valid", out_valid, 1'b1);
    check("bp_hold_sub", out_signal[1], 1'b1);
    check("bp_hold_pc", out_pc, 32'h200);
    out_ready = 1'b1;
    for (int k = 0; k < accepts; k++) begin
      check("bp_drain_valid", out_valid, 1'b1);
      check("bp_drain_pc", out_pc, 32'h200 + 32'(k) * 4);
      @(posedge clk); #1;
    end
    check("bp_drain_done", out_valid, 1'b0);

    // Flush with one instruction registered and one buffered
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h300 + 32'(k) * 4;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("fl_pre_valid", out_valid, 1'b1);
    check("fl_pre_in_ready", in_ready, 1'b1);
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h999; in_instr = 32'h00500093;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("fl_out_valid", out_valid, 1'b0);
    check("fl_count_zero", in_ready, 1'b1);
    out_ready = 1'b1; seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("fl_nothing_output", seen, 0);

    // Sustained throughput
    do_reset();
    out_ready = 1'b1; nvalid = 0; first = -1; last = -1; order_bad = 0; rdy_drop = 0;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 8); in_instr = 32'h00500093; in_pc = 32'h400 + 32'(c) * 4;
      if (c < 8 && !in_ready) rdy_drop++;
      @(posedge clk); #1;
      if (out_valid) begin
        if (out_pc != 32'h400 + 32'(nvalid) * 4) order_bad++;
        if (first < 0) first = c;
        last = c;
        nvalid++;
      end
    end
    in_valid = 1'b0;
    check("tp_count", nvalid, 8);
    check("tp_contiguous", last - first + 1, 8);
    check("tp_order", order_bad, 0);
    check("tp_in_ready", rdy_drop, 0);

    // Reset in the middle of traffic
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_instr = 32'hFE208EE3; in_pc = 32'h500 + 32'(k) * 4;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mrst_valid", out_valid, 1'b0);
    check("mrst_in_ready", in_ready, 1'b1);
    check("mrst_fields", pack_out(), exp_t'('0));
    out_ready = 1'b1; seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("mrst_nothing_output", seen, 0);

    // Randomized traffic against the reference model
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = gen_instr();
      in_pc     = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 99) == 0);
      #1;
      if (flush) q.delete();
      else begin
        if (out_valid && out_ready) begin
          if (q.size() == 0) check("rand_spurious_valid", out_valid, 1'b0);
          else begin
            e = q.pop_front();
            check("rand_txn", pack_out(), e);
          end
        end
        if (in_valid && in_ready) q.push_back(ref_decode(in_instr, in_pc));
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) begin
        if (q.size() == 0) check("rand_spurious_valid", out_valid, 1'b0);
        else begin
          e = q.pop_front();
          check("rand_txn", pack_out(), e);
        end
      end
      @(posedge clk); #1;
    end
    check("rand_drain_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
